// File: rtl/screen_fb_if.sv
// CPU-facing word port of the screen framebuffer (Hack SCREEN region).
// The CPU side drives in/address/load and reads back out combinationally.
interface screen_fb_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 13
);
    logic [WIDTH-1:0]  in;
    logic [ADDR_W-1:0] address;
    logic              load;
    logic [WIDTH-1:0]  out;

    modport master (output in, output address, output load, input out);
    modport slave  (input in, input address, input load, output out);
endinterface

// File: rtl/screen_fb.sv
// Hack-compatible screen framebuffer with a raster scan-out engine.
// The CPU port reads combinationally and writes on the clock; the scan engine
// streams the whole framebuffer one pixel per clock, LSB of each word first.
module screen_fb #(
    parameter int WIDTH         = 16,
    parameter int ROWS          = 256,
    parameter int WORDS_PER_ROW = 32,
    parameter int ADDR_W        = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    screen_fb_if.slave        cpu,
    input  logic              scan_en,
    output logic              pixel,
    output logic              pixel_valid,
    output logic              line_start,
    output logic              frame_start,
    output logic [ADDR_W-1:0] scan_addr
);
    localparam int DEPTH  = ROWS * WORDS_PER_ROW;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int WORD_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [ADDR_W:0]   LIMIT     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WIDTH - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_ROW - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;

    logic [WIDTH-1:0]  mem [DEPTH];
    state_t            state;
    logic [WIDTH-1:0]  shift_reg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] word_cnt;
    logic [ROW_W-1:0]  row_cnt;

    logic              cpu_hit;
    logic [IDX_W-1:0]  cpu_idx;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] scan_rd_addr;
    logic [WIDTH-1:0]  scan_data;

    // Address decode: anything past the framebuffer is neither written nor read.
    assign cpu_hit = {1'b0, cpu.address} < LIMIT;
    assign cpu_idx = cpu.address[IDX_W-1:0];
    assign cpu.out = cpu_hit ? mem[cpu_idx] : '0;

    // The scan address walks the array linearly, which equals row*WORDS_PER_ROW+word.
    assign next_addr    = (scan_addr == LAST_ADDR) ? '0 : scan_addr + ADDR_W'(1);
    assign scan_rd_addr = (state == SHIFT) ? next_addr : scan_addr;
    assign scan_data    = mem[scan_rd_addr[IDX_W-1:0]];

    // CPU write port into the framebuffer array.
    // NOTE: the array has no reset branch; resetting a memory would stop it mapping onto RAM.
    always_ff @(posedge clk) begin
        if (cpu.load && cpu_hit)
            mem[cpu_idx] <= cpu.in;
    end

    // Scan FSM: IDLE -> FETCH -> SHIFT, reloading the next word with no gap.
    // NOTE: non-blocking assignments make every register see pre-edge values, so a CPU
    // write and a scan load of the same word on one edge is read-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            row_cnt     <= '0;
            scan_addr   <= '0;
            pixel_valid <= 1'b0;
        end else if (state != IDLE && !scan_en) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            row_cnt     <= '0;
            scan_addr   <= '0;
            pixel_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (scan_en) begin
                        state     <= FETCH;
                        scan_addr <= '0;
                    end
                end
                FETCH: begin
                    shift_reg   <= scan_data;
                    bit_cnt     <= '0;
                    pixel_valid <= 1'b1;
                    state       <= SHIFT;
                end
                SHIFT: begin
                    if (bit_cnt != LAST_BIT) begin
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_cnt + BIT_W'(1);
                    end else begin
                        shift_reg <= scan_data;
                        bit_cnt   <= '0;
                        scan_addr <= next_addr;
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= '0;
                            row_cnt  <= (row_cnt == LAST_ROW) ? '0 : row_cnt + ROW_W'(1);
                        end else begin
                            word_cnt <= word_cnt + WORD_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pixel and sync strobes decode directly from the registered scan state.
    assign pixel       = pixel_valid & shift_reg[0];
    assign line_start  = pixel_valid && (bit_cnt == '0) && (word_cnt == '0);
    assign frame_start = line_start && (row_cnt == '0);
endmodule
